readback_serializer: RTL

READBACK_SERIALIZER -- requirements
Module: readback_serializer

---
 rtl/readback_serializer_pkg.sv | 6 +
 rtl/readback_serializer_if.sv | 25 ++
 rtl/readback_serializer_lane_pick.sv | 21 ++
 rtl/readback_serializer.sv | 115 +++++++++++
 4 files changed

// File: rtl/readback_serializer_pkg.sv
// readback_serializer_pkg: shared FSM states and constants for the readback serializer (package ols_pkg)
package ols_pkg;
    localparam int SETTLE_CYCLES = 2;
    localparam int LANES = 4;
    typedef enum logic [2:0] {IDLE, SETTLE, LOAD, SEND, ADV} state_e;
endpackage

// File: rtl/readback_serializer_if.sv
// readback_serializer_if: control, sample-memory and byte-stream signals of the readback serializer
interface readback_serializer_if #(
    parameter int MDW = 32,
    parameter int CW = 16
);
    logic start;
    logic [CW-1:0] count;
    logic rd_ready;
    logic rd_valid;
    logic [3:0] rd_keep;
    logic [MDW-1:0] rd_data;
    logic [7:0] tx_data;
    logic tx_valid;
    logic tx_ready;
    logic busy;
    logic done;
    modport master (
        input start, count, rd_valid, rd_keep, rd_data, tx_ready,
        output rd_ready, tx_data, tx_valid, busy, done
    );
    modport slave (
        output start, count, rd_valid, rd_keep, rd_data, tx_ready,
        input rd_ready, tx_data, tx_valid, busy, done
    );
endinterface

// File: rtl/readback_serializer_lane_pick.sv
// rb_lane_pick: finds the lowest set mask lane at or above 'from'; none=1 when no such lane exists
module rb_lane_pick
    import ols_pkg::*;
(
    input  logic [LANES-1:0] mask,
    input  logic [2:0]       from,
    output logic [1:0]       lane,
    output logic             none
);
    // scan downward so the lowest qualifying lane is the one left standing
    always_comb begin
        lane = '0;
        none = 1'b1;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mask[i] && from <= 3'(i)) begin
                lane = 2'(i);
                none = 1'b0;
            end
        end
    end
endmodule

// File: rtl/readback_serializer.sv
// readback_serializer: reads count+1 memory words and streams their kept bytes, lane 0 first.
// Build option RB_PAD_EN: send all four lanes of every word, substituting 0x00 for unkept lanes.
module readback_serializer
    import ols_pkg::*;
#(
    parameter int MDW = 32,
    parameter int CW = 16
) (
    input logic clk,
    input logic rst,
    readback_serializer_if.master bus
);
    state_e state_q, state_d;
    logic [1:0] settle_q, settle_d;
    logic [CW-1:0] remaining_q, remaining_d;
    logic [MDW-1:0] word_q, word_d;
    logic [LANES-1:0] mask_q, mask_d;
    logic [1:0] lane_q, lane_d;
    logic [LANES-1:0] pick_mask;
    logic [2:0] pick_from;
    logic [1:0] pick_lane;
    logic pick_none;
    logic [7:0] lane_byte;
    logic done_c;

    rb_lane_pick u_pick (
        .mask(pick_mask),
        .from(pick_from),
        .lane(pick_lane),
        .none(pick_none)
    );

    // in LOAD search the incoming keep from lane 0, in SEND search the held mask past the current lane
    always_comb begin
`ifdef RB_PAD_EN
        pick_mask = '1;
        lane_byte = mask_q[lane_q] ? word_q[8*lane_q +: 8] : 8'h00;
`else
        pick_mask = (state_q == LOAD) ? bus.rd_keep : mask_q;
        lane_byte = word_q[8*lane_q +: 8];
`endif
        pick_from = (state_q == LOAD) ? 3'd0 : {1'b0, lane_q} + 3'd1;
    end

    // next-state and datapath updates; done fires combinationally on the final accepted byte
    always_comb begin
        state_d = state_q;
        settle_d = settle_q;
        remaining_d = remaining_q;
        word_d = word_q;
        mask_d = mask_q;
        lane_d = lane_q;
        done_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    remaining_d = bus.count;
                    settle_d = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                settle_d = settle_q + 2'd1;
                state_d = (settle_q == 2'(SETTLE_CYCLES - 1)) ? LOAD : SETTLE;
            end
            LOAD: begin
                if (bus.rd_valid) begin
                    word_d = bus.rd_data;
                    mask_d = bus.rd_keep;
                    lane_d = pick_lane;
                    done_c = pick_none && remaining_q == '0;
                    state_d = !pick_none ? SEND : (remaining_q == '0) ? IDLE : ADV;
                end
            end
            SEND: begin
                if (bus.tx_ready) begin
                    lane_d = pick_none ? lane_q : pick_lane;
                    done_c = pick_none && remaining_q == '0;
                    state_d = !pick_none ? SEND : (remaining_q == '0) ? IDLE : ADV;
                end
            end
            ADV: begin
                remaining_d = remaining_q - 1'b1;
                settle_d = '0;
                state_d = SETTLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state register; reset clears everything so no stale byte or step survives
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            settle_q <= '0;
            remaining_q <= '0;
            word_q <= '0;
            mask_q <= '0;
            lane_q <= '0;
        end else begin
            state_q <= state_d;
            settle_q <= settle_d;
            remaining_q <= remaining_d;
            word_q <= word_d;
            mask_q <= mask_d;
            lane_q <= lane_d;
        end
    end

    assign bus.tx_valid = state_q == SEND;
    assign bus.tx_data = (state_q == SEND) ? lane_byte : 8'h00;
    assign bus.rd_ready = state_q == ADV;
    assign bus.busy = state_q != IDLE;
    assign bus.done = done_c;
endmodule
